// File: rtl/tl_pkg.sv
// Shared TileLink-UL definitions for the fragmenter-side register bridge:
// A/D opcode encodings, the bridge FSM state type and small opcode helpers.
package tl_pkg;

    // A-channel opcodes
    localparam logic [2:0] TL_PUT_FULL        = 3'd0;
    localparam logic [2:0] TL_PUT_PARTIAL     = 3'd1;
    localparam logic [2:0] TL_ARITHMETIC_DATA = 3'd2;
    localparam logic [2:0] TL_LOGICAL_DATA    = 3'd3;
    localparam logic [2:0] TL_GET             = 3'd4;

    // D-channel opcodes
    localparam logic [2:0] TL_ACCESS_ACK      = 3'd0;
    localparam logic [2:0] TL_ACCESS_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Opcodes that carry write data and map to a register write.
    function automatic logic is_put(input logic [2:0] op);
        return (op == TL_PUT_FULL) || (op == TL_PUT_PARTIAL);
    endfunction

    // Opcodes whose response must carry data, even when rejected.
    function automatic logic is_get_class(input logic [2:0] op);
        return (op == TL_GET) || (op == TL_ARITHMETIC_DATA) || (op == TL_LOGICAL_DATA);
    endfunction

endpackage

// File: rtl/tl_regbus_bridge_if.sv
// Bundle of the TL-UL A/D channels and the req/ack register bus seen by the
// bridge. The slave modport is the bridge's view; master is the environment.
interface tl_regbus_bridge_if #(
    parameter int ADDR_W = 28,
    parameter int SRC_W  = 10
) ();

    // TL A channel
    logic              a_ready;
    logic              a_valid;
    logic [2:0]        a_opcode;
    logic [2:0]        a_param;
    logic [1:0]        a_size;
    logic [SRC_W-1:0]  a_source;
    logic [ADDR_W-1:0] a_address;
    logic [3:0]        a_mask;
    logic [31:0]       a_data;
    logic              a_corrupt;

    // TL D channel
    logic              d_ready;
    logic              d_valid;
    logic [2:0]        d_opcode;
    logic [1:0]        d_size;
    logic [SRC_W-1:0]  d_source;
    logic [31:0]       d_data;

    // Register bus
    logic              reg_req;
    logic              reg_we;
    logic [ADDR_W-3:0] reg_addr;
    logic [3:0]        reg_be;
    logic [31:0]       reg_wdata;
    logic              reg_ack;
    logic [31:0]       reg_rdata;

    modport slave (
        output a_ready,
        input  a_valid, a_opcode, a_param, a_size, a_source, a_address,
        input  a_mask, a_data, a_corrupt,
        input  d_ready,
        output d_valid, d_opcode, d_size, d_source, d_data,
        output reg_req, reg_we, reg_addr, reg_be, reg_wdata,
        input  reg_ack, reg_rdata
    );

    modport master (
        input  a_ready,
        output a_valid, a_opcode, a_param, a_size, a_source, a_address,
        output a_mask, a_data, a_corrupt,
        output d_ready,
        input  d_valid, d_opcode, d_size, d_source, d_data,
        input  reg_req, reg_we, reg_addr, reg_be, reg_wdata,
        output reg_ack, reg_rdata
    );

endinterface

// File: rtl/tl_regbus_bridge.sv
// Single-beat TL-UL slave behind the fragmenter: each accepted A beat becomes
// one req/ack register access, answered on D. A watchdog bounds the wait for
// reg_ack so a hung peripheral cannot stall the fragmenter.
module tl_regbus_bridge
    import tl_pkg::*;
#(
    parameter int          ADDR_W  = 28,
    parameter int          SRC_W   = 10,
    parameter int          TIMEOUT = 255,
    parameter logic [31:0] TO_DATA = 32'hDEAD_BEEF
) (
    input  logic                  clock,
    input  logic                  reset,
    tl_regbus_bridge_if.slave     bus,
    output logic                  timeout_pulse
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    // Last count at which the access may still be acked; expiry fires here.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_e            state_reg;
    logic [CNT_W-1:0]  cnt_reg;
    logic              a_ready_reg;
    logic              d_valid_reg;
    logic [2:0]        d_opcode_reg;
    logic [1:0]        d_size_reg;
    logic [SRC_W-1:0]  d_source_reg;
    logic [31:0]       d_data_reg;
    logic              reg_req_reg;
    logic              reg_we_reg;
    logic [ADDR_W-3:0] reg_addr_reg;
    logic [3:0]        reg_be_reg;
    logic [31:0]       reg_wdata_reg;
    logic              timeout_pulse_reg;

    logic a_fire;
    logic a_supported;
    logic resp_has_data;
    logic unused_inputs;

    assign a_fire        = bus.a_valid & a_ready_reg;
    assign a_supported   = (is_put(bus.a_opcode) || (bus.a_opcode == TL_GET))
                           && (bus.a_size != 2'd3);
    // The D opcode chosen at accept time doubles as the "this was a Get" flag.
    assign resp_has_data = (d_opcode_reg == TL_ACCESS_ACK_DATA);
    // a_param and the byte offset within the word carry no meaning here.
    assign unused_inputs = ^{bus.a_param, bus.a_address[1:0]};

    // Bridge FSM: accept one A beat, run the register access, hold D until taken.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state_reg         <= IDLE;
            cnt_reg           <= '0;
            a_ready_reg       <= 1'b0;
            d_valid_reg       <= 1'b0;
            d_opcode_reg      <= '0;
            d_size_reg        <= '0;
            d_source_reg      <= '0;
            d_data_reg        <= '0;
            reg_req_reg       <= 1'b0;
            reg_we_reg        <= 1'b0;
            reg_addr_reg      <= '0;
            reg_be_reg        <= '0;
            reg_wdata_reg     <= '0;
            timeout_pulse_reg <= 1'b0;
        end else begin
            timeout_pulse_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    a_ready_reg <= 1'b1;
                    if (a_fire) begin
                        a_ready_reg  <= 1'b0;
                        d_size_reg   <= bus.a_size;
                        d_source_reg <= bus.a_source;
                        d_data_reg   <= '0;
                        d_opcode_reg <= is_get_class(bus.a_opcode) ? TL_ACCESS_ACK_DATA
                                                                   : TL_ACCESS_ACK;
                        if (a_supported) begin
                            state_reg     <= ACCESS;
                            cnt_reg       <= '0;
                            reg_req_reg   <= 1'b1;
                            reg_we_reg    <= is_put(bus.a_opcode);
                            reg_addr_reg  <= bus.a_address[ADDR_W-1:2];
                            reg_wdata_reg <= bus.a_data;
                            // A corrupt Put still runs the bus cycle but writes no bytes.
                            if (!is_put(bus.a_opcode)) begin
                                reg_be_reg <= 4'hF;
                            end else if (bus.a_corrupt) begin
                                reg_be_reg <= 4'h0;
                            end else begin
                                reg_be_reg <= bus.a_mask;
                            end
                        end else begin
                            state_reg   <= RESP;
                            d_valid_reg <= 1'b1;
                        end
                    end
                end
                ACCESS: begin
                    if (bus.reg_ack) begin
                        // Ack wins over a simultaneous watchdog expiry.
                        reg_req_reg <= 1'b0;
                        d_valid_reg <= 1'b1;
                        state_reg   <= RESP;
                        if (resp_has_data) begin
                            d_data_reg <= bus.reg_rdata;
                        end
                    end else if (cnt_reg == CNT_LAST) begin
                        reg_req_reg       <= 1'b0;
                        timeout_pulse_reg <= 1'b1;
                        d_valid_reg       <= 1'b1;
                        state_reg         <= RESP;
                        cnt_reg           <= CNT_MAX;
                        if (resp_has_data) begin
                            d_data_reg <= TO_DATA;
                        end
                    end else if (cnt_reg != CNT_MAX) begin
                        cnt_reg <= cnt_reg + 1'b1;
                    end
                end
                RESP: begin
                    if (bus.d_ready) begin
                        d_valid_reg <= 1'b0;
                        a_ready_reg <= 1'b1;
                        state_reg   <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign bus.a_ready    = a_ready_reg;
    assign bus.d_valid    = d_valid_reg;
    assign bus.d_opcode   = d_opcode_reg;
    assign bus.d_size     = d_size_reg;
    assign bus.d_source   = d_source_reg;
    assign bus.d_data     = d_data_reg;
    assign bus.reg_req    = reg_req_reg;
    assign bus.reg_we     = reg_we_reg;
    assign bus.reg_addr   = reg_addr_reg;
    assign bus.reg_be     = reg_be_reg;
    assign bus.reg_wdata  = reg_wdata_reg;
    assign timeout_pulse  = timeout_pulse_reg;

endmodule

// File: tb/tb_tl_regbus_bridge.sv
// Directed bench for tl_regbus_bridge: a main instance with the default
// watchdog and a second instance with TIMEOUT=4 for the expiry cases.
module tb_tl_regbus_bridge;
    import tl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic tp;
    logic tp_to;

    int n_tests = 0;
    int n_fail  = 0;

    tl_regbus_bridge_if #(.ADDR_W(28), .SRC_W(10)) bus_if ();
    tl_regbus_bridge_if #(.ADDR_W(28), .SRC_W(10)) bus_to ();

    tl_regbus_bridge #(
        .ADDR_W(28), .SRC_W(10), .TIMEOUT(255), .TO_DATA(32'hDEAD_BEEF)
    ) dut (
        .clock(clk), .reset(rst_n), .bus(bus_if), .timeout_pulse(tp)
    );

    tl_regbus_bridge #(
        .ADDR_W(28), .SRC_W(10), .TIMEOUT(4), .TO_DATA(32'hDEAD_BEEF)
    ) dut_to (
        .clock(clk), .reset(rst_n), .bus(bus_to), .timeout_pulse(tp_to)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end else begin
            $display("[TB] ok   %s = 0x%08h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus_if.a_valid = 0; bus_if.a_opcode = 0; bus_if.a_param = 0; bus_if.a_size = 0;
        bus_if.a_source = 0; bus_if.a_address = 0; bus_if.a_mask = 0; bus_if.a_data = 0;
        bus_if.a_corrupt = 0; bus_if.d_ready = 0; bus_if.reg_ack = 0; bus_if.reg_rdata = 0;
        bus_to.a_valid = 0; bus_to.a_opcode = 0; bus_to.a_param = 0; bus_to.a_size = 0;
        bus_to.a_source = 0; bus_to.a_address = 0; bus_to.a_mask = 0; bus_to.a_data = 0;
        bus_to.a_corrupt = 0; bus_to.d_ready = 0; bus_to.reg_ack = 0; bus_to.reg_rdata = 0;
    endtask

    // Present one A beat, wait (bounded) for a_ready, let it fire, then drop a_valid.
    task automatic send_a(input string tag, input logic [2:0] op, input logic [1:0] size,
                          input logic [9:0] src, input logic [27:0] addr,
                          input logic [3:0] mask, input logic [31:0] data,
                          input logic corrupt);
        int n;
        bus_if.a_opcode = op;   bus_if.a_size = size;  bus_if.a_source = src;
        bus_if.a_address = addr; bus_if.a_mask = mask; bus_if.a_data = data;
        bus_if.a_corrupt = corrupt; bus_if.a_param = 3'd5; bus_if.a_valid = 1'b1;
        n = 0;
        while (!bus_if.a_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus_if.a_ready) check_eq({tag, "_a_ready_wait"}, 32'd0, 32'd1);
        tick();
        bus_if.a_valid = 1'b0;
    endtask

    // Hold off the ack for 'delay' cycles of reg_req, then ack once with rdata.
    task automatic device_ack(input string tag, input int delay, input logic [31:0] rdata);
        int lost;
        lost = 0;
        for (int i = 0; i < delay; i++) begin
            if (!bus_if.reg_req) lost++;
            tick();
        end
        if (!bus_if.reg_req) lost++;
        check_eq({tag, "_req_held"}, 32'(lost), 32'd0);
        bus_if.reg_ack = 1'b1;
        bus_if.reg_rdata = rdata;
        tick();
        bus_if.reg_ack = 1'b0;
        bus_if.reg_rdata = 32'h0;
        check_eq({tag, "_req_drop"}, 32'(bus_if.reg_req), 32'd0);
    endtask

    // Wait (bounded) for d_valid, check the response fields, then take it.
    task automatic expect_d(input string tag, input logic [2:0] op, input logic [31:0] data,
                            input logic [9:0] src, input logic [1:0] size);
        int n;
        n = 0;
        while (!bus_if.d_valid && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_d_valid"},  32'(bus_if.d_valid),  32'd1);
        check_eq({tag, "_d_opcode"}, 32'(bus_if.d_opcode), 32'(op));
        check_eq({tag, "_d_data"},   bus_if.d_data,        data);
        check_eq({tag, "_d_source"}, 32'(bus_if.d_source), 32'(src));
        check_eq({tag, "_d_size"},   32'(bus_if.d_size),   32'(size));
        bus_if.d_ready = 1'b1;
        tick();
        bus_if.d_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL global_timeout: simulation did not finish");
        $fatal(1, "global timeout");
    end

    initial begin
        int req_cnt, pulse_cnt, pulse_with_d, bad, a_fires, d_fires;

        // ---------------- reset ----------------
        idle_inputs();
        rst_n = 1'b0;
        repeat (3) tick();
        check_eq("rst_a_ready",  32'(bus_if.a_ready),  32'd0);
        check_eq("rst_d_valid",  32'(bus_if.d_valid),  32'd0);
        check_eq("rst_reg_req",  32'(bus_if.reg_req),  32'd0);
        check_eq("rst_tpulse",   32'(tp),              32'd0);
        check_eq("rst_reg_be",   32'(bus_if.reg_be),   32'd0);
        check_eq("rst_reg_addr", 32'(bus_if.reg_addr), 32'd0);
        check_eq("rst_d_data",   bus_if.d_data,        32'd0);
        rst_n = 1'b1;
        check_eq("rel_a_ready_low", 32'(bus_if.a_ready), 32'd0);
        tick();
        check_eq("rel_a_ready_high", 32'(bus_if.a_ready), 32'd1);

        // ---------------- Get, zero-wait device ----------------
        send_a("get1", TL_GET, 2'd2, 10'h2A5, 28'h0000104, 4'hF, 32'h0, 1'b0);
        check_eq("get1_reg_req",  32'(bus_if.reg_req),  32'd1);
        check_eq("get1_reg_addr", 32'(bus_if.reg_addr), 32'h41);
        check_eq("get1_reg_be",   32'(bus_if.reg_be),   32'hF);
        check_eq("get1_reg_we",   32'(bus_if.reg_we),   32'd0);
        device_ack("get1", 0, 32'h1234_5678);
        expect_d("get1", TL_ACCESS_ACK_DATA, 32'h1234_5678, 10'h2A5, 2'd2);
        check_eq("get1_a_ready_again", 32'(bus_if.a_ready), 32'd1);

        // ---------------- PutPartial, slow device ----------------
        send_a("putp", TL_PUT_PARTIAL, 2'd2, 10'h011, 28'h0000200, 4'b0110, 32'hAABB_CCDD, 1'b0);
        check_eq("putp_reg_we",    32'(bus_if.reg_we),   32'd1);
        check_eq("putp_reg_be",    32'(bus_if.reg_be),   32'h6);
        check_eq("putp_reg_wdata", bus_if.reg_wdata,     32'hAABB_CCDD);
        check_eq("putp_reg_addr",  32'(bus_if.reg_addr), 32'h80);
        device_ack("putp", 5, 32'hFFFF_FFFF);
        expect_d("putp", TL_ACCESS_ACK, 32'h0, 10'h011, 2'd2);

        // ---------------- corrupt PutFull: no bytes enabled ----------------
        send_a("corr", TL_PUT_FULL, 2'd2, 10'h012, 28'h0000010, 4'hF, 32'h1111_2222, 1'b1);
        check_eq("corr_reg_req", 32'(bus_if.reg_req), 32'd1);
        check_eq("corr_reg_we",  32'(bus_if.reg_we),  32'd1);
        check_eq("corr_reg_be",  32'(bus_if.reg_be),  32'h0);
        device_ack("corr", 1, 32'h0);
        expect_d("corr", TL_ACCESS_ACK, 32'h0, 10'h012, 2'd2);

        // ---------------- watchdog expiry (TIMEOUT=4 instance) ----------------
        bus_to.a_opcode = TL_GET; bus_to.a_size = 2'd2; bus_to.a_source = 10'h003;
        bus_to.a_address = 28'h10; bus_to.a_mask = 4'hF; bus_to.a_valid = 1'b1;
        check_eq("to_a_ready", 32'(bus_to.a_ready), 32'd1);
        tick();
        bus_to.a_valid = 1'b0;
        req_cnt = 0; pulse_cnt = 0; pulse_with_d = 0;
        for (int i = 0; i < 12; i++) begin
            if (bus_to.reg_req) req_cnt++;
            if (tp_to) pulse_cnt++;
            if (tp_to && bus_to.d_valid) pulse_with_d++;
            tick();
        end
        check_eq("to_req_cycles",  32'(req_cnt),          32'd4);
        check_eq("to_pulse_count", 32'(pulse_cnt),        32'd1);
        check_eq("to_pulse_with_d", 32'(pulse_with_d),    32'd1);
        check_eq("to_d_valid",     32'(bus_to.d_valid),   32'd1);
        check_eq("to_d_opcode",    32'(bus_to.d_opcode),  32'(TL_ACCESS_ACK_DATA));
        check_eq("to_d_data",      bus_to.d_data,         32'hDEAD_BEEF);
        check_eq("to_d_source",    32'(bus_to.d_source),  32'h003);
        bus_to.d_ready = 1'b1;
        tick();
        bus_to.d_ready = 1'b0;

        // ack arriving on the expiry cycle wins
        bus_to.a_source = 10'h004; bus_to.a_valid = 1'b1;
        tick();
        bus_to.a_valid = 1'b0;
        check_eq("edge_req_start", 32'(bus_to.reg_req), 32'd1);
        repeat (3) tick();
        check_eq("edge_req_last", 32'(bus_to.reg_req), 32'd1);
        bus_to.reg_ack = 1'b1; bus_to.reg_rdata = 32'hCAFE_F00D;
        tick();
        bus_to.reg_ack = 1'b0; bus_to.reg_rdata = 32'h0;
        check_eq("edge_no_pulse", 32'(tp_to),          32'd0);
        check_eq("edge_d_valid",  32'(bus_to.d_valid), 32'd1);
        check_eq("edge_d_data",   bus_to.d_data,       32'hCAFE_F00D);
        bus_to.d_ready = 1'b1;
        tick();
        bus_to.d_ready = 1'b0;

        // ---------------- unsupported beats ----------------
        send_a("hint", 3'd5, 2'd2, 10'h005, 28'h20, 4'hF, 32'h0, 1'b0);
        check_eq("hint_no_req", 32'(bus_if.reg_req), 32'd0);
        expect_d("hint", TL_ACCESS_ACK, 32'h0, 10'h005, 2'd2);
        send_a("put_sz3", TL_PUT_FULL, 2'd3, 10'h006, 28'h20, 4'hF, 32'h5555_5555, 1'b0);
        check_eq("put_sz3_no_req", 32'(bus_if.reg_req), 32'd0);
        expect_d("put_sz3", TL_ACCESS_ACK, 32'h0, 10'h006, 2'd3);
        send_a("get_sz3", TL_GET, 2'd3, 10'h007, 28'h20, 4'hF, 32'h0, 1'b0);
        check_eq("get_sz3_no_req", 32'(bus_if.reg_req), 32'd0);
        expect_d("get_sz3", TL_ACCESS_ACK_DATA, 32'h0, 10'h007, 2'd3);
        send_a("arith", TL_ARITHMETIC_DATA, 2'd2, 10'h008, 28'h20, 4'hF, 32'h1, 1'b0);
        check_eq("arith_no_req", 32'(bus_if.reg_req), 32'd0);
        expect_d("arith", TL_ACCESS_ACK_DATA, 32'h0, 10'h008, 2'd2);

        // ---------------- D backpressure with a queued A beat ----------------
        send_a("stall", TL_GET, 2'd2, 10'h099, 28'h40, 4'hF, 32'h0, 1'b0);
        device_ack("stall", 0, 32'h55AA_33CC);
        bus_if.a_opcode = TL_GET; bus_if.a_source = 10'h09A; bus_if.a_address = 28'h44;
        bus_if.a_valid = 1'b1;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            if (bus_if.d_valid !== 1'b1 || bus_if.d_data !== 32'h55AA_33CC ||
                bus_if.d_source !== 10'h099 || bus_if.d_opcode !== TL_ACCESS_ACK_DATA ||
                bus_if.a_ready !== 1'b0 || bus_if.reg_req !== 1'b0) bad++;
            tick();
        end
        check_eq("stall_stable", 32'(bad), 32'd0);
        expect_d("stall", TL_ACCESS_ACK_DATA, 32'h55AA_33CC, 10'h099, 2'd2);
        tick();
        bus_if.a_valid = 1'b0;
        check_eq("queued_reg_req",  32'(bus_if.reg_req),  32'd1);
        check_eq("queued_reg_addr", 32'(bus_if.reg_addr), 32'h11);
        device_ack("queued", 2, 32'h0000_9A9A);
        expect_d("queued", TL_ACCESS_ACK_DATA, 32'h0000_9A9A, 10'h09A, 2'd2);

        // ---------------- throughput: 3 cycles per beat, stray ack ignored ----------------
        bus_if.a_opcode = TL_GET; bus_if.a_size = 2'd2; bus_if.a_source = 10'h001;
        bus_if.a_address = 28'h80; bus_if.reg_ack = 1'b1; bus_if.reg_rdata = 32'h0F0F_0F0F;
        bus_if.d_ready = 1'b1; bus_if.a_valid = 1'b1;
        check_eq("tput_start_ready", 32'(bus_if.a_ready), 32'd1);
        a_fires = 0; d_fires = 0; bad = 0;
        for (int i = 0; i < 30; i++) begin
            if (bus_if.a_valid && bus_if.a_ready) a_fires++;
            if (bus_if.d_valid && bus_if.d_ready) begin
                d_fires++;
                if (bus_if.d_data !== 32'h0F0F_0F0F) bad++;
            end
            tick();
        end
        bus_if.a_valid = 1'b0; bus_if.reg_ack = 1'b0; bus_if.d_ready = 1'b0;
        check_eq("tput_a_fires", 32'(a_fires), 32'd10);
        check_eq("tput_d_fires", 32'(d_fires), 32'd10);
        check_eq("tput_d_data",  32'(bad),     32'd0);
        tick();

        // ---------------- reset during ACCESS ----------------
        send_a("rstmid", TL_GET, 2'd2, 10'h03C, 28'h300, 4'hF, 32'h0, 1'b0);
        check_eq("rstmid_req", 32'(bus_if.reg_req), 32'd1);
        rst_n = 1'b0;
        tick();
        check_eq("rstmid_req_drop", 32'(bus_if.reg_req), 32'd0);
        check_eq("rstmid_d_valid",  32'(bus_if.d_valid), 32'd0);
        check_eq("rstmid_a_ready",  32'(bus_if.a_ready), 32'd0);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus_if.d_valid || bus_if.reg_req) bad++;
            tick();
        end
        check_eq("rstmid_no_resp", 32'(bad), 32'd0);
        send_a("fresh", TL_GET, 2'd2, 10'h03D, 28'h304, 4'hF, 32'h0, 1'b0);
        check_eq("fresh_reg_addr", 32'(bus_if.reg_addr), 32'hC1);
        device_ack("fresh", 0, 32'h0BAD_F00D);
        expect_d("fresh", TL_ACCESS_ACK_DATA, 32'h0BAD_F00D, 10'h03D, 2'd2);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
